// File: rtl/sc_spi_pkg.sv
// rtl/sc_spi_pkg.sv - shared types and constants for the SPI transfer sequencer
package sc_spi_pkg;

    localparam int SPI_DW  = 32;
    localparam int BURST_W = 8;

    localparam logic [SPI_DW-1:0] DUMMY_WORD = 32'h0000_0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_STORE,
        S_FINISH
    } seq_state_t;

endpackage

// File: rtl/sc_spi_sfifo.sv
// rtl/sc_spi_sfifo.sv - synchronous first-word-fall-through FIFO with level/full/empty
module sc_spi_sfifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] count;
    logic             push;
    logic             pop;

    assign full  = (count == FULL_LVL);
    assign empty = (count == '0);
    assign level = count;

    // A push into a full FIFO is only accepted when the head leaves in the same cycle.
    assign push = wr_en && (!full || rd_en);
    assign pop  = rd_en && !empty;

    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sc_spi_xfer_seq.sv
// rtl/sc_spi_xfer_seq.sv - burst sequencer with TX/RX word FIFOs in front of the SPI engine
module sc_spi_xfer_seq
    import sc_spi_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1,
    parameter int BUSY_TMO   = 255
) (
    input  logic               SYSCLK,
    input  logic               SYSRST,
    input  logic               TXF_WE,
    input  logic [SPI_DW-1:0]  TXF_WDATA,
    output logic               TXF_FULL,
    output logic [LVL_W-1:0]   TXF_LEVEL,
    input  logic               RXF_RE,
    output logic [SPI_DW-1:0]  RXF_RDATA,
    output logic               RXF_EMPTY,
    output logic [LVL_W-1:0]   RXF_LEVEL,
    input  logic               SEQ_GO,
    input  logic               SEQ_ABORT,
    input  logic [BURST_W-1:0] BURST_LEN,
    output logic               SEQ_BUSY,
    output logic               SEQ_DONE,
    output logic               SEQ_ABORTED,
    output logic               TX_UDF,
    output logic               RX_OVF,
    output logic               TXSTART,
    output logic               CSEXTEND,
    output logic [SPI_DW-1:0]  TXDATA,
    input  logic [SPI_DW-1:0]  RXDATA,
    input  logic               SPIBUSY,
    input  logic               SPICOMPLETE
);

    localparam int TMO_W = $clog2(BUSY_TMO + 1);
    localparam logic [TMO_W-1:0]   TMO_LAST = TMO_W'(BUSY_TMO - 1);
    localparam logic [BURST_W:0]   REM_ONE  = (BURST_W+1)'(1);
    localparam logic [BURST_W:0]   REM_MAX  = {1'b1, {BURST_W{1'b0}}};

    seq_state_t        state;
    seq_state_t        state_nx;
    logic [BURST_W:0]  remaining;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              abort_pending;
    logic              aborted_q;
    logic              udf_q;
    logic              ovf_q;
    logic              csext_q;
    logic [SPI_DW-1:0] txdata_q;
    logic [SPI_DW-1:0] rx_cap;

    logic              tx_rd_en;
    logic [SPI_DW-1:0] tx_rdata;
    logic              tx_empty;
    logic              rx_wr_en;
    logic              rx_full;

    logic              seq_busy;
    logic              load_word;
    logic              load_dummy;
    logic              load_csext;
    logic              set_udf;
    logic              set_tmo;
    logic              cap_rx;

    sc_spi_sfifo #(.DEPTH(FIFO_DEPTH), .WIDTH(SPI_DW), .LVL_W(LVL_W)) u_tx_fifo (
        .clk     (SYSCLK),
        .rst     (SYSRST),
        .wr_en   (TXF_WE),
        .wr_data (TXF_WDATA),
        .rd_en   (tx_rd_en),
        .rd_data (tx_rdata),
        .full    (TXF_FULL),
        .empty   (tx_empty),
        .level   (TXF_LEVEL)
    );

    sc_spi_sfifo #(.DEPTH(FIFO_DEPTH), .WIDTH(SPI_DW), .LVL_W(LVL_W)) u_rx_fifo (
        .clk     (SYSCLK),
        .rst     (SYSRST),
        .wr_en   (rx_wr_en),
        .wr_data (rx_cap),
        .rd_en   (RXF_RE),
        .rd_data (RXF_RDATA),
        .full    (rx_full),
        .empty   (RXF_EMPTY),
        .level   (RXF_LEVEL)
    );

    assign seq_busy    = (state != S_IDLE) && (state != S_FINISH);
    assign SEQ_BUSY    = seq_busy;
    assign SEQ_DONE    = (state == S_FINISH);
    assign TXSTART     = (state == S_START);
    assign CSEXTEND    = csext_q;
    assign TXDATA      = txdata_q;
    assign SEQ_ABORTED = aborted_q;
    assign TX_UDF      = udf_q;
    assign RX_OVF      = ovf_q;
    assign rx_wr_en    = (state == S_STORE);

    always_comb begin
        state_nx   = state;
        tx_rd_en   = 1'b0;
        load_word  = 1'b0;
        load_dummy = 1'b0;
        load_csext = 1'b0;
        set_udf    = 1'b0;
        set_tmo    = 1'b0;
        cap_rx     = 1'b0;
        case (state)
            S_IDLE: begin
                if (SEQ_GO) state_nx = S_LOAD;
            end
            S_LOAD: begin
                // csext_q doubles as "CS is still held by the previous word".
                if (abort_pending && !csext_q) begin
                    state_nx = S_FINISH;
                end else if (abort_pending) begin
                    load_word  = 1'b1;
                    tx_rd_en   = !tx_empty;
                    load_dummy = tx_empty;
                    state_nx   = S_START;
                end else if (!tx_empty) begin
                    load_word  = 1'b1;
                    tx_rd_en   = 1'b1;
                    load_csext = (remaining != REM_ONE);
                    state_nx   = S_START;
                end else begin
                    set_udf = 1'b1;
                end
            end
            S_START: begin
                state_nx = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (SPICOMPLETE) begin
                    cap_rx   = 1'b1;
                    state_nx = S_STORE;
                end else if (SPIBUSY) begin
                    state_nx = S_WAIT_DONE;
                end else if (tmo_cnt == TMO_LAST) begin
                    set_tmo  = 1'b1;
                    state_nx = S_FINISH;
                end
            end
            S_WAIT_DONE: begin
                if (SPICOMPLETE) begin
                    cap_rx   = 1'b1;
                    state_nx = S_STORE;
                end
            end
            S_STORE: begin
                if ((remaining == REM_ONE) || (abort_pending && !csext_q)) begin
                    state_nx = S_FINISH;
                end else begin
                    state_nx = S_LOAD;
                end
            end
            S_FINISH: begin
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge SYSCLK) begin
        if (SYSRST) begin
            state         <= S_IDLE;
            remaining     <= '0;
            tmo_cnt       <= '0;
            abort_pending <= 1'b0;
            aborted_q     <= 1'b0;
            udf_q         <= 1'b0;
            ovf_q         <= 1'b0;
            csext_q       <= 1'b0;
            txdata_q      <= '0;
            rx_cap        <= '0;
        end else begin
            state <= state_nx;
            if ((state == S_IDLE) && SEQ_GO) begin
                remaining     <= (BURST_LEN == '0) ? REM_MAX : {1'b0, BURST_LEN};
                abort_pending <= 1'b0;
                aborted_q     <= 1'b0;
                udf_q         <= 1'b0;
                ovf_q         <= 1'b0;
                csext_q       <= 1'b0;
            end
            if (load_word) begin
                txdata_q <= load_dummy ? DUMMY_WORD : tx_rdata;
                csext_q  <= load_csext;
            end
            if (state == S_START) begin
                tmo_cnt <= '0;
            end else if (state == S_WAIT_BUSY) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            if (cap_rx) begin
                rx_cap <= RXDATA;
            end
            if (state == S_STORE) begin
                remaining <= remaining - 1'b1;
                if (rx_full && !RXF_RE) ovf_q <= 1'b1;
            end
            if (seq_busy && SEQ_ABORT) begin
                abort_pending <= 1'b1;
                aborted_q     <= 1'b1;
            end
            if (set_tmo) aborted_q <= 1'b1;
            if (set_udf) udf_q <= 1'b1;
        end
    end

endmodule
